noc_rr_arbiter: RTL and testbench



---
 rtl/noc_rr_arbiter.sv | 165 ++++++++++++++++
 tb/tb_noc_rr_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_rr_arbiter.sv
// Wormhole round-robin output-port arbiter: pops NUM_IN FIFO heads into a registered valid/ready flit stream.
// Optional packet counter output pkt_count is enabled with the NOC_ARB_STATS_EN macro.
module noc_rr_arbiter #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_empty,
    output logic [NUM_IN-1:0]       in_rd_en,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    locked,
    output logic                    err_drop
`ifdef NOC_ARB_STATS_EN
    ,
    output logic [15:0]             pkt_count
`endif
);

    localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     grant_q, grant_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              err_drop_q, err_drop_d;

    logic              load;
    logic [NUM_IN-1:0] cand, orphan, rd_en;
    logic              win_found, orph_found;
    logic [PW-1:0]     win_idx, orph_idx, sel_idx;
    logic [WIDTH-1:0]  sel_flit;

    function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] idx);
        return (int'(idx) == NUM_IN - 1) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        cand   = '0;
        orphan = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            cand[i]   = !in_empty[i] &&  in_data[i*WIDTH + WIDTH - 1];
            orphan[i] = !in_empty[i] && !in_data[i*WIDTH + WIDTH - 1];
        end
    end

    // Scanning downward and overwriting leaves the first hit at/after the pointer (with wrap).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (cand[(int'(ptr_q) + k) % NUM_IN]) begin
                win_found = 1'b1;
                win_idx   = PW'((int'(ptr_q) + k) % NUM_IN);
            end
        end
    end

    always_comb begin
        orph_found = 1'b0;
        orph_idx   = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (orphan[k]) begin
                orph_found = 1'b1;
                orph_idx   = PW'(k);
            end
        end
    end

    always_comb begin
        sel_idx  = (state_q == IDLE) ? win_idx : grant_q;
        sel_flit = in_data[int'(sel_idx)*WIDTH +: WIDTH];
    end

    always_comb begin
        load        = !out_valid_q || out_ready;
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_drop_d  = 1'b0;
        rd_en       = '0;
        if (load) begin
            out_valid_d = 1'b0;
            if (state_q == IDLE) begin
                if (win_found) begin
                    rd_en[win_idx] = 1'b1;
                    out_data_d     = sel_flit;
                    out_valid_d    = 1'b1;
                    grant_d        = win_idx;
                    if (sel_flit[WIDTH-2]) begin
                        ptr_d = inc_wrap(win_idx);
                    end else begin
                        state_d = LOCKED;
                    end
                end else if (orph_found) begin
                    rd_en[orph_idx] = 1'b1;
                    err_drop_d      = 1'b1;
                end
            end else if (!in_empty[grant_q]) begin
                rd_en[grant_q] = 1'b1;
                out_data_d     = sel_flit;
                out_valid_d    = 1'b1;
                if (sel_flit[WIDTH-2]) begin
                    state_d = IDLE;
                    ptr_d   = inc_wrap(grant_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_drop_q  <= err_drop_d;
        end
    end

    assign in_rd_en  = rst_n ? rd_en : '0;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign locked    = (state_q == LOCKED);
    assign err_drop  = err_drop_q;

`ifdef NOC_ARB_STATS_EN
    logic [15:0] pkt_count_q, pkt_count_d;

    // Counts packets as their tail is handed downstream, not when popped.
    always_comb begin
        pkt_count_d = pkt_count_q;
        if (out_valid_q && out_ready && out_data_q[WIDTH-2]) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Self-checking bench for noc_rr_arbiter: FIFO models feed the DUT, a scoreboard queue holds expected output flits.
module tb_noc_rr_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_empty;
    logic [N-1:0]   in_rd_en;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           locked;
    logic           err_drop;
`ifdef NOC_ARB_STATS_EN
    logic [15:0]    pkt_count;
`endif

    int checks = 0;
    int failures = 0;
    logic [W-1:0] sb [$];
    logic [W-1:0] exp_flit;

    logic [W-1:0] mem [N][16];
    int wp [N] = '{default: 0};
    int rp [N] = '{default: 0};

    noc_rr_arbiter #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .locked    (locked),
        .err_drop  (err_drop)
`ifdef NOC_ARB_STATS_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        in_data  = '0;
        in_empty = '0;
        for (int i = 0; i < N; i++) begin
            in_empty[i]        = (rp[i] == wp[i]);
            in_data[i*W +: W]  = mem[i][rp[i] % 16];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (in_rd_en[i]) rp[i] <= rp[i] + 1;
        end
    end

    function automatic logic [W-1:0] mk(input bit h, input bit t, input logic [29:0] p);
        return {h, t, p};
    endfunction

    task automatic push_flit(input int i, input logic [W-1:0] f);
        mem[i][wp[i] % 16] = f;
        wp[i] = wp[i] + 1;
    endtask

    task automatic test_reset();
        logic [W-1:0] a;
        a = mk(1, 1, 30'h0AB);
        rst_n = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        push_flit(0, a);
        sb.push_back(a);
        #1;
        checks++; if (in_rd_en !== 4'b0000) begin failures++; $display("[TB] FAIL reset_rd_en got=%b exp=0000", in_rd_en); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (err_drop !== 1'b0) begin failures++; $display("[TB] FAIL reset_err_drop got=%b exp=0", err_drop); end
    endtask

    task automatic test_single_flit();
        logic [W-1:0] b0, b1;
        b0 = mk(1, 1, 30'h010);
        b1 = mk(1, 1, 30'h011);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) rst_n = 1'b1;
            if (c == 2) begin
                push_flit(0, b0);
                push_flit(1, b1);
                sb.push_back(b1);
                sb.push_back(b0);
            end
            #1;
            if (c == 0) begin
                checks++; if (in_rd_en !== 4'b0001) begin failures++; $display("[TB] FAIL single_rd_en got=%b exp=0001", in_rd_en); end
            end
            if (c == 1) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid got=%b exp=1", out_valid); end
                checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL single_locked got=%b exp=0", locked); end
            end
            if (c == 2) begin
                checks++; if (in_rd_en !== 4'b0010) begin failures++; $display("[TB] FAIL single_ptr1_rd_en got=%b exp=0010", in_rd_en); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("[TB] FAIL single_unexpected got=%h exp=none", out_data);
                end else begin
                    exp_flit = sb.pop_front();
                    if (out_data !== exp_flit) begin failures++; $display("[TB] FAIL single_data got=%h exp=%h", out_data, exp_flit); end
                end
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL single_drain got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_round_robin();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                for (int i = 0; i < N; i++) begin
                    push_flit(i, mk(1, 1, 30'h200 + 30'(i)));
                    sb.push_back(mk(1, 1, 30'h200 + 30'(i)));
                end
            end
            #1;
            if (c >= 1 && c <= 4) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL rr_no_bubble c=%0d got=%b exp=1", c, out_valid); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("[TB] FAIL rr_unexpected got=%h exp=none", out_data);
                end else begin
                    exp_flit = sb.pop_front();
                    if (out_data !== exp_flit) begin failures++; $display("[TB] FAIL rr_data got=%h exp=%h", out_data, exp_flit); end
                end
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL rr_drain got=%0d exp=0", sb.size()); end
`ifdef NOC_ARB_STATS_EN
        checks++; if (pkt_count !== 16'd4) begin failures++; $display("[TB] FAIL rr_pkt_count got=%0d exp=4", pkt_count); end
`endif
    endtask

    task automatic test_locked();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                push_flit(1, mk(1, 1, 30'h100));
                sb.push_back(mk(1, 1, 30'h100));
            end
            if (c == 1) begin
                push_flit(2, mk(1, 0, 30'h300));
                push_flit(2, mk(0, 0, 30'h301));
                push_flit(2, mk(0, 1, 30'h302));
                push_flit(1, mk(1, 1, 30'h101));
                sb.push_back(mk(1, 0, 30'h300));
                sb.push_back(mk(0, 0, 30'h301));
                sb.push_back(mk(0, 1, 30'h302));
                sb.push_back(mk(1, 1, 30'h101));
            end
            #1;
            if (c == 1) begin
                checks++; if (in_rd_en !== 4'b0100) begin failures++; $display("[TB] FAIL lock_grant_rd_en got=%b exp=0100", in_rd_en); end
            end
            if (c == 2 || c == 3) begin
                checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL lock_locked c=%0d got=%b exp=1", c, locked); end
            end
            if (c == 3) begin
                checks++; if (in_rd_en !== 4'b0100) begin failures++; $display("[TB] FAIL lock_tail_rd_en got=%b exp=0100", in_rd_en); end
            end
            if (c == 4) begin
                checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL lock_release got=%b exp=0", locked); end
                checks++; if (in_rd_en !== 4'b0010) begin failures++; $display("[TB] FAIL lock_next_rd_en got=%b exp=0010", in_rd_en); end
            end
            if (c >= 2 && c <= 5) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL lock_contig c=%0d got=%b exp=1", c, out_valid); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("[TB] FAIL lock_unexpected got=%h exp=none", out_data);
                end else begin
                    exp_flit = sb.pop_front();
                    if (out_data !== exp_flit) begin failures++; $display("[TB] FAIL lock_data got=%h exp=%h", out_data, exp_flit); end
                end
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL lock_drain got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_starve();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                push_flit(0, mk(1, 0, 30'h400));
                push_flit(0, mk(0, 0, 30'h401));
                sb.push_back(mk(1, 0, 30'h400));
                sb.push_back(mk(0, 0, 30'h401));
            end
            if (c == 2) push_flit(3, mk(1, 1, 30'h403));
            if (c == 6) begin
                push_flit(0, mk(0, 1, 30'h402));
                sb.push_back(mk(0, 1, 30'h402));
                sb.push_back(mk(1, 1, 30'h403));
            end
            #1;
            if (c == 0 || c == 6) begin
                checks++; if (in_rd_en !== 4'b0001) begin failures++; $display("[TB] FAIL starve_rd_en0 c=%0d got=%b exp=0001", c, in_rd_en); end
            end
            if (c >= 2 && c <= 5) begin
                checks++; if (in_rd_en !== 4'b0000) begin failures++; $display("[TB] FAIL starve_no_pop c=%0d got=%b exp=0000", c, in_rd_en); end
            end
            if (c >= 3 && c <= 5) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL starve_valid_low c=%0d got=%b exp=0", c, out_valid); end
            end
            if (c >= 1 && c <= 6) begin
                checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL starve_locked c=%0d got=%b exp=1", c, locked); end
            end
            if (c == 7) begin
                checks++; if (in_rd_en !== 4'b1000) begin failures++; $display("[TB] FAIL starve_next_rd_en got=%b exp=1000", in_rd_en); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("[TB] FAIL starve_unexpected got=%h exp=none", out_data);
                end else begin
                    exp_flit = sb.pop_front();
                    if (out_data !== exp_flit) begin failures++; $display("[TB] FAIL starve_data got=%h exp=%h", out_data, exp_flit); end
                end
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL starve_drain got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] h;
        h = mk(1, 0, 30'h500);
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            out_ready = (c == 0 || c >= 6);
            if (c == 0) begin
                push_flit(1, h);
                push_flit(1, mk(0, 0, 30'h501));
                push_flit(1, mk(0, 1, 30'h502));
                sb.push_back(h);
                sb.push_back(mk(0, 0, 30'h501));
                sb.push_back(mk(0, 1, 30'h502));
            end
            #1;
            if (c >= 1 && c <= 5) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid c=%0d got=%b exp=1", c, out_valid); end
                checks++; if (out_data !== h) begin failures++; $display("[TB] FAIL bp_hold c=%0d got=%h exp=%h", c, out_data, h); end
                checks++; if (in_rd_en !== 4'b0000) begin failures++; $display("[TB] FAIL bp_no_pop c=%0d got=%b exp=0000", c, in_rd_en); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("[TB] FAIL bp_unexpected got=%h exp=none", out_data);
                end else begin
                    exp_flit = sb.pop_front();
                    if (out_data !== exp_flit) begin failures++; $display("[TB] FAIL bp_data got=%h exp=%h", out_data, exp_flit); end
                end
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL bp_drain got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_orphan();
`ifdef NOC_ARB_STATS_EN
        logic [15:0] cnt_before;
        cnt_before = pkt_count;
`endif
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (c == 0) push_flit(1, mk(0, 0, 30'h055));
            #1;
            if (c == 0) begin
                checks++; if (in_rd_en !== 4'b0010) begin failures++; $display("[TB] FAIL orphan_rd_en got=%b exp=0010", in_rd_en); end
            end
            if (c == 1) begin
                checks++; if (err_drop !== 1'b1) begin failures++; $display("[TB] FAIL orphan_pulse got=%b exp=1", err_drop); end
                checks++; if (in_rd_en !== 4'b0000) begin failures++; $display("[TB] FAIL orphan_rd_en_after got=%b exp=0000", in_rd_en); end
            end
            if (c == 2) begin
                checks++; if (err_drop !== 1'b0) begin failures++; $display("[TB] FAIL orphan_pulse_end got=%b exp=0", err_drop); end
            end
            if (c >= 1) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL orphan_valid c=%0d got=%b exp=0", c, out_valid); end
            end
        end
`ifdef NOC_ARB_STATS_EN
        checks++; if (pkt_count !== cnt_before) begin failures++; $display("[TB] FAIL orphan_pkt_count got=%0d exp=%0d", pkt_count, cnt_before); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_round_robin();
        test_locked();
        test_starve();
        test_backpressure();
        test_orphan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
